// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver with frame-synchronous double buffering.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
    parameter int NDIG           = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] digits,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   blank,
    input  logic              load,
    output logic [7:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    localparam logic [7:0]      SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NDIG-1:0] AN_OFF     = (DIG_ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              pending_q, pending_d;
    logic [4*NDIG-1:0] sh_digits_q, sh_digits_d, disp_digits_q, disp_digits_d;
    logic [NDIG-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
    logic [NDIG-1:0]   sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
    logic [7:0]        seg_q, seg_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              tick_q, tick_d;

    logic              advance, boundary;
    logic [3:0]        nib [NDIG];
    logic [NDIG-1:0]   an_onehot;
    logic [NDIG-1:0]   dark;
    logic [7:0]        seg_raw;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            assign nib[gi]       = disp_digits_q[4*gi +: 4];
            assign an_onehot[gi] = (idx_q == IW'(gi));
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_lsd
                assign dark[gi] = disp_blank_q[gi];
            end else begin : g_upper
                // A digit is a leading zero when it and every digit above it are zero.
                assign dark[gi] = disp_blank_q[gi] |
                                  ((disp_digits_q[4*NDIG-1:4*gi] == '0) && !disp_dp_q[gi]);
            end
`else
            assign dark[gi] = disp_blank_q[gi];
`endif
        end
    endgenerate

    always_comb begin
        advance       = (presc_q == PRESC_LAST);
        boundary      = advance && (idx_q == IDX_LAST);
        presc_d       = advance ? '0 : presc_q + 1'b1;
        idx_d         = idx_q;
        pending_d     = pending_q;
        sh_digits_d   = sh_digits_q;
        sh_dp_d       = sh_dp_q;
        sh_blank_d    = sh_blank_q;
        disp_digits_d = disp_digits_q;
        disp_dp_d     = disp_dp_q;
        disp_blank_d  = disp_blank_q;

        if (advance) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Display registers only change on the frame boundary, so a frame is never torn.
        if (load) begin
            if (boundary) begin
                disp_digits_d = digits;
                disp_dp_d     = dp;
                disp_blank_d  = blank;
                pending_d     = 1'b0;
            end else begin
                sh_digits_d = digits;
                sh_dp_d     = dp;
                sh_blank_d  = blank;
                pending_d   = 1'b1;
            end
        end else if (boundary && pending_q) begin
            disp_digits_d = sh_digits_q;
            disp_dp_d     = sh_dp_q;
            disp_blank_d  = sh_blank_q;
            pending_d     = 1'b0;
        end

        seg_raw = dark[idx_q] ? 8'h00 : {disp_dp_q[idx_q], seg_decode(nib[idx_q])};
        seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        an_d    = (DIG_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
        tick_d  = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            disp_digits_q <= '0;
            disp_dp_q     <= '0;
            disp_blank_q  <= '0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            tick_q        <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            disp_digits_q <= disp_digits_d;
            disp_dp_q     <= disp_dp_d;
            disp_blank_q  <= disp_blank_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            tick_q        <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed 7-segment display driver for NDIG hex digits with one shared segment bus and per-digit enables.
- Replaces the per-digit combinational hex decoders in the clock display path.
- Adds a scan prescaler, frame-synchronous double-buffered digit capture, per-digit blanking and decimal points, and a frame tick.
- Sits between the time/counter core and the board LED pins.

Parameters:
- NDIG, 8: number of digits scanned, 1..16.
- SCAN_DIV, 50000: clk cycles each digit is lit, >=1.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs inverted (lit = 0).
- DIG_ACTIVE_LOW, 1: 1 = digit enables inverted (selected = 0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digits  in  4*NDIG  hex nibbles; digit i = digits[4i+3:4i], digit 0 = rightmost
- dp  in  NDIG  decimal point per digit, 1 = lit
- blank  in  NDIG  1 = digit i fully dark
- load  in  1  one-cycle strobe; captures digits/dp/blank into shadow registers
- seg  out  8  [6:0] = segments g..a (bit0 = a), [7] = dp, polarity per SEG_ACTIVE_LOW
- an  out  NDIG  digit enables, one-hot when active, polarity per DIG_ACTIVE_LOW
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit NDIG-1 to digit 0

Behaviour:
- Reset, synchronous on rst=1:
  - prescaler = 0, index = 0, pending = 0.
  - Shadow and display registers = 0.
  - seg = all segments off (8'hFF if SEG_ACTIVE_LOW, else 8'h00).
  - an = all digits off.
  - frame_tick = 0.
  - load is ignored while rst=1.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps; "advance" is asserted at count SCAN_DIV-1.
  - With SCAN_DIV=1, advance is asserted every cycle.
- Index:
  - On advance, index increments; it wraps NDIG-1 -> 0.
  - The wrap cycle is the frame boundary.
  - With NDIG=1, every advance is a boundary.
- frame_tick: registered and high for exactly the one cycle following the boundary advance.
- Double buffering:
  - load=1 copies the inputs into shadow registers and sets pending.
  - Multiple loads before a boundary: the last one wins.
  - At a frame boundary with pending=1, shadow is copied to display and pending is cleared.
  - load in the same cycle as a boundary: the new input data goes straight to display and pending stays 0.
  - Display content never changes mid-frame.
- Decode table, active-high value before polarity:
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07
  - 8 7F, 9 6F, A 77, B 7C, C 39, D 5E, E 79, F 71
  - seg[7] = display dp[index].
- Blanking: if display blank[index]=1, seg = all off including dp, but an still selects the digit.
- Output timing:
  - seg and an are registered and reflect the current index with 1 cycle of latency after index changes.
  - Both update in the same cycle, so an is never two-hot.
- Polarity: applied at the output register only.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Each display digit i (i>=1) whose nibble and all higher nibbles are 0, with dp clear, is treated as blanked.
  - Digit 0 is never suppressed.
  - Suppression is evaluated on display registers, so it is frame-synchronous.
- Undefined: zeros are shown normally, and there is no extra logic.

Test Plan:
- Reset: NDIG=4, SCAN_DIV=3, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1. Hold rst 5 cycles -> seg=8'hFF, an=4'hF, frame_tick=0 throughout. Release -> first digit lit after 1 cycle, an=4'b1110.
- Scan order: load digits=16'h4321, dp=0, blank=0, then wait one frame -> an sequence 1110, 1101, 1011, 0111, each held 3 cycles. seg = ~06, ~5B, ~4F, ~66. frame_tick pulses once per 12 cycles.
- Double buffer: load 16'h4321, wait until mid-frame, load 16'hABCD -> rest of frame still shows 1..4. Next frame shows D,C,B,A (~5E, ~39, ~7C, ~77). Load coincident with boundary -> visible in the frame starting then.
- dp/blank: dp=4'b0010, blank=4'b1000, digits=16'h0090 -> digit1 seg=~(8'h80|8'h6F)=8'h10. Digit3 seg=8'hFF with an=0111.
- Reset mid-frame: assert rst while an=1011 -> next cycle all off, index 0, pending cleared, display registers zero; a pre-reset load is not shown.
- LEADING_ZERO_BLANK_EN defined: digits=16'h0005 -> digits 3..1 dark, digit0 ~6D. digits=16'h0000 -> only digit0 shows ~3F. Macro undefined: same stimulus -> all digits ~3F except digit0 ~6D.
